// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared DAS timing defaults and channel state type
package tetris_pkg;

  localparam int DAS_DELAY_DEFAULT = 16;
  localparam int DAS_SPEED_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } das_state_t;

endpackage

// File: rtl/input_manager_if.sv
// rtl/input_manager_if.sv - button levels, game tick and command pulses bundle
interface input_manager_if;

  logic tick_game;
  logic raw_left;
  logic raw_right;
  logic raw_down;
  logic raw_rotate;
  logic raw_drop;
  logic cmd_left;
  logic cmd_right;
  logic cmd_down;
  logic cmd_rotate;
  logic cmd_drop;

  modport master (
    output tick_game, raw_left, raw_right, raw_down, raw_rotate, raw_drop,
    input  cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop
  );

  modport slave (
    input  tick_game, raw_left, raw_right, raw_down, raw_rotate, raw_drop,
    output cmd_left, cmd_right, cmd_down, cmd_rotate, cmd_drop
  );

endinterface

// File: rtl/das_channel.sv
// rtl/das_channel.sv - one-shot plus delayed auto-shift repeat for one button
module das_channel
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY = DAS_DELAY_DEFAULT,
  parameter int DAS_SPEED = DAS_SPEED_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic raw,
  output logic cmd
);

  localparam int DW = (DAS_DELAY < 1) ? 1 : $clog2(DAS_DELAY + 1);
  localparam int RW = (DAS_SPEED <= 2) ? 1 : $clog2(DAS_SPEED);
  localparam logic [DW-1:0] DAS_MAX = DW'(DAS_DELAY);
  localparam logic [RW-1:0] REP_MAX = RW'(DAS_SPEED - 1);

  das_state_t    state_q, state_d;
  logic [DW-1:0] das_cnt_q, das_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          prev_q;
  logic          cmd_q, cmd_d;

  // State, counters, previous level and registered pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      das_cnt_q <= '0;
      rep_cnt_q <= '0;
      prev_q    <= 1'b0;
      cmd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      das_cnt_q <= das_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      prev_q    <= raw;
      cmd_q     <= cmd_d;
    end
  end

  // Release wins, then press edge (swallows a coincident tick), then tick-driven DAS
  always_comb begin
    state_d   = state_q;
    das_cnt_d = das_cnt_q;
    rep_cnt_d = rep_cnt_q;
    cmd_d     = 1'b0;
    if (!raw) begin
      state_d   = IDLE;
      das_cnt_d = '0;
      rep_cnt_d = '0;
    end else if (!prev_q) begin
      cmd_d     = 1'b1;
      state_d   = DELAY;
      das_cnt_d = '0;
      rep_cnt_d = '0;
    end else if (tick_game) begin
      case (state_q)
        DELAY: begin
          if (das_cnt_q == DAS_MAX) begin
            state_d   = REPEAT;
            rep_cnt_d = REP_MAX;
          end else begin
            das_cnt_d = das_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (rep_cnt_q == REP_MAX) begin
            cmd_d     = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd = cmd_q;

endmodule

// File: rtl/input_manager.sv
// rtl/input_manager.sv - player buttons to single-cycle game command pulses
module input_manager
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY = DAS_DELAY_DEFAULT,
  parameter int DAS_SPEED = DAS_SPEED_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input_manager_if.slave  bus
);

  logic cmd_left, cmd_right, cmd_down;
  logic prev_rotate, prev_drop;
  logic cmd_rotate_q, cmd_drop_q;

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED)) u_left (
    .clk(clk), .rst(rst), .tick_game(bus.tick_game), .raw(bus.raw_left), .cmd(cmd_left)
  );

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED)) u_right (
    .clk(clk), .rst(rst), .tick_game(bus.tick_game), .raw(bus.raw_right), .cmd(cmd_right)
  );

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_SPEED(DAS_SPEED)) u_down (
    .clk(clk), .rst(rst), .tick_game(bus.tick_game), .raw(bus.raw_down), .cmd(cmd_down)
  );

  // Rotate and hard-drop fire once per press, never repeat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_rotate  <= 1'b0;
      prev_drop    <= 1'b0;
      cmd_rotate_q <= 1'b0;
      cmd_drop_q   <= 1'b0;
    end else begin
      prev_rotate  <= bus.raw_rotate;
      prev_drop    <= bus.raw_drop;
      cmd_rotate_q <= bus.raw_rotate & ~prev_rotate;
      cmd_drop_q   <= bus.raw_drop & ~prev_drop;
    end
  end

  assign bus.cmd_left   = cmd_left;
  assign bus.cmd_right  = cmd_right;
  assign bus.cmd_down   = cmd_down;
  assign bus.cmd_rotate = cmd_rotate_q;
  assign bus.cmd_drop   = cmd_drop_q;

endmodule

// File: tb/tb_input_manager.sv
// tb/tb_input_manager.sv - directed bench with tick-count model of input_manager
module tb_input_manager;

  localparam int D = 16;
  localparam int S = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   tick_num;
  int   q_left[$];
  int   q_right[$];
  int   q_down[$];
  int   n_rot;
  int   n_drop;
  int   want[$];

  input_manager_if bus ();

  input_manager #(.DAS_DELAY(D), .DAS_SPEED(S)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_seq(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) chk({name, "_tick"}, got[i], exp[i]);
    end
  endtask

  // Model: a DAS button pulses on its press edge, then on the n-th held tick
  // after the press whenever n = D+2+k*S; one-shot buttons only on press.
  logic [4:0] raw_v, prev_v, exp_v;
  int         held[3];

  always_comb raw_v = {bus.raw_drop, bus.raw_rotate, bus.raw_down, bus.raw_right, bus.raw_left};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_v = '0;
      exp_v  = '0;
      for (int i = 0; i < 3; i++) held[i] = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp_v[i] = 1'b0;
        if (raw_v[i] && !prev_v[i]) begin
          exp_v[i] = 1'b1;
          if (i < 3) held[i] = 0;
        end else if (i < 3) begin
          if (!raw_v[i]) begin
            held[i] = 0;
          end else if (bus.tick_game) begin
            held[i] = held[i] + 1;
            exp_v[i] = (held[i] >= D + 2) && (((held[i] - D - 2) % S) == 0);
          end
        end
      end
      prev_v = raw_v;
    end
  end

  // Every-cycle compare against the model, plus pulse logging per tick number
  always @(negedge clk) begin
    chk("cmd_left",   int'(bus.cmd_left),   int'(exp_v[0]));
    chk("cmd_right",  int'(bus.cmd_right),  int'(exp_v[1]));
    chk("cmd_down",   int'(bus.cmd_down),   int'(exp_v[2]));
    chk("cmd_rotate", int'(bus.cmd_rotate), int'(exp_v[3]));
    chk("cmd_drop",   int'(bus.cmd_drop),   int'(exp_v[4]));
    if (bus.cmd_left)   q_left.push_back(tick_num);
    if (bus.cmd_right)  q_right.push_back(tick_num);
    if (bus.cmd_down)   q_down.push_back(tick_num);
    if (bus.cmd_rotate) n_rot++;
    if (bus.cmd_drop)   n_drop++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick_num++;
    bus.tick_game = 1'b1;
    @(posedge clk);
    #1;
    bus.tick_game = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_left"},   int'(bus.cmd_left),   0);
    chk({name, "_right"},  int'(bus.cmd_right),  0);
    chk({name, "_down"},   int'(bus.cmd_down),   0);
    chk({name, "_rotate"}, int'(bus.cmd_rotate), 0);
    chk({name, "_drop"},   int'(bus.cmd_drop),   0);
  endtask

  initial begin
    total = 0; bad = 0; tick_num = 0; n_rot = 0; n_drop = 0;
    rst = 1'b0;
    bus.tick_game = 1'b0;
    bus.raw_left = 1'b0; bus.raw_right = 1'b0; bus.raw_down = 1'b0;
    bus.raw_rotate = 1'b0; bus.raw_drop = 1'b0;
    cyc(3);
    chk_all_zero("reset");
    rst = 1'b1;
    cyc(2);

    // Rotate held 12 cycles: one pulse; release: nothing more
    n_rot = 0;
    bus.raw_rotate = 1'b1;
    cyc(12);
    chk("rotate_hold_pulses", n_rot, 1);
    bus.raw_rotate = 1'b0;
    cyc(3);
    chk("rotate_release_pulses", n_rot, 1);

    // Hard drop: one pulse per press
    n_drop = 0;
    bus.raw_drop = 1'b1; cyc(4); bus.raw_drop = 1'b0; cyc(2);
    bus.raw_drop = 1'b1; cyc(4); bus.raw_drop = 1'b0; cyc(2);
    chk("drop_two_presses", n_drop, 2);

    // Left held: press pulse, repeats on ticks 18,22 then 26,30
    q_left.delete(); tick_num = 0;
    bus.raw_left = 1'b1;
    cyc(2);
    repeat (22) do_tick();
    want = '{0, 18, 22};
    chk_seq("left_to22", q_left, want);
    repeat (8) do_tick();
    want = '{0, 18, 22, 26, 30};
    chk_seq("left_to30", q_left, want);
    bus.raw_left = 1'b0;
    do_tick();
    q_left.delete(); tick_num = 0;
    bus.raw_left = 1'b1;
    cyc(2);
    want = '{0};
    chk_seq("left_repress", q_left, want);
    bus.raw_left = 1'b0;
    cyc(2);

    // Left and right together: aligned schedules
    q_left.delete(); q_right.delete(); tick_num = 0;
    bus.raw_left = 1'b1; bus.raw_right = 1'b1;
    cyc(2);
    repeat (18) do_tick();
    want = '{0, 18};
    chk_seq("pair_left", q_left, want);
    chk_seq("pair_right", q_right, want);
    bus.raw_left = 1'b0; bus.raw_right = 1'b0;
    cyc(2);

    // Down released at tick 17, re-pressed on tick 20: next repeat at 38
    q_down.delete(); tick_num = 0;
    bus.raw_down = 1'b1;
    cyc(2);
    repeat (17) do_tick();
    bus.raw_down = 1'b0;
    repeat (2) do_tick();
    bus.raw_down = 1'b1;
    do_tick();
    repeat (18) do_tick();
    want = '{0, 20, 38};
    chk_seq("down_repress", q_down, want);
    bus.raw_down = 1'b0;
    cyc(2);

    // Reset while left is pulsing in REPEAT, then restart from press
    q_left.delete(); tick_num = 0;
    bus.raw_left = 1'b1;
    cyc(2);
    repeat (17) do_tick();
    tick_num++;
    bus.tick_game = 1'b1;
    @(posedge clk);
    #1;
    bus.tick_game = 1'b0;
    chk("left_pulse_before_rst", int'(bus.cmd_left), 1);
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    cyc(2);
    q_left.delete(); tick_num = 0;
    rst = 1'b1;
    cyc(2);
    repeat (18) do_tick();
    want = '{0, 18};
    chk_seq("left_after_rst", q_left, want);
    bus.raw_left = 1'b0;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_manager.md
Name: input_manager

Overview:
- Converts five synchronous, already-debounced player button levels into single-cycle game command pulses for the game-logic FSM.
- Rotate and hard-drop are pure one-shots: one pulse per press.
- Left, right and soft-down are one-shots plus delayed auto-shift (DAS) auto-repeat, timed in game ticks (`tick_game`), not clock cycles.

Parameters:
- DAS_DELAY, 16, number of held game ticks before auto-repeat arms.
- DAS_SPEED, 4, auto-repeat period in game ticks once armed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- tick_game  input  1  one-clk-wide game frame strobe.
- raw_left  input  1  left button level.
- raw_right  input  1  right button level.
- raw_down  input  1  soft-drop button level.
- raw_rotate  input  1  rotate button level.
- raw_drop  input  1  hard-drop button level.
- cmd_left  output  1  move-left pulse.
- cmd_right  output  1  move-right pulse.
- cmd_down  output  1  move-down pulse.
- cmd_rotate  output  1  rotate pulse.
- cmd_drop  output  1  hard-drop pulse.

Behaviour:
- Decided: single clock `clk`; reset `rst` is asynchronous and active-low.
- Reset (rst=0): all `cmd_*` = 0, all previous-level registers = 0, all counters = 0, all DAS channels IDLE.
- Consequence of reset: a button already high at reset release produces a pulse on the first clock edge.
- All outputs are registered. Each pulse is exactly 1 clk wide and visible after the rising edge at which the causing condition is sampled (latency 1 edge).
- Edge detect: per button, `prev <= raw` every cycle. A press is `raw & ~prev`.
- One-shot (rotate, drop): `cmd <= raw & ~prev`. Holding the button produces no further pulses. Release produces nothing.
- DAS channel (left, right, down), states IDLE, DELAY, REPEAT:
  - Press edge (any state): emit immediate pulse; `das_cnt` := 0; go DELAY. A `tick_game` coincident with the edge cycle is ignored.
  - DELAY, on tick while held: if `das_cnt == DAS_DELAY`, go REPEAT with `rep_cnt` := DAS_SPEED-1 (no pulse); else `das_cnt`++.
  - REPEAT, on tick while held: if `rep_cnt == DAS_SPEED-1`, pulse and `rep_cnt` := 0; else `rep_cnt`++.
  - Resulting timing (held-tick numbers counted from the first tick after the press edge): no pulses on ticks 1..DAS_DELAY+1; repeat pulses on ticks DAS_DELAY+2+k·DAS_SPEED. With defaults: 18, 22, 26, …
  - Release (raw=0): go IDLE immediately, clear counters, no pulse.
  - Ticks while IDLE or released: no effect.
  - Re-press after release: restarts from an immediate pulse.
- Channels are fully independent. Left and right held together each fire on their own schedule; arbitration is the consumer's job.
- Counter widths: `das_cnt` is $clog2(DAS_DELAY+1) bits; `rep_cnt` is $clog2(DAS_SPEED) bits with a minimum of 1. No wrap occurs because counting stops at the thresholds.
- Mid-operation reset clears everything immediately (asynchronous).

Decomposition:
- Shared package `tetris_pkg`: DAS_DELAY_DEFAULT=16 and DAS_SPEED_DEFAULT=4 as localparams; channel state enum {IDLE, DELAY, REPEAT}.
- One sub-module `das_channel` (clk, rst, tick_game, raw, cmd, parameters DAS_DELAY and DAS_SPEED), instantiated 3×.
- Rotate and drop one-shots are inline in the top module.

Test Plan:
- Reset then raw_rotate=1 held 12 cycles → cmd_rotate=1 for exactly the first cycle after the first edge, 0 for the remaining 11; release → no pulse.
- raw_left=1 held, then 22 ticks spaced 2 clk apart → cmd_left pulse right after the press edge; none on ticks 1–17; pulses on ticks 18 and 22; none on 19–21.
- Continue holding to tick 30 → pulses on ticks 26 and 30 only (period 4). Release at tick 31, re-press → immediate pulse, DAS restarts.
- raw_left and raw_right asserted same cycle → both cmd_left and cmd_right pulse that cycle; repeats align on identical ticks.
- Release raw_down at tick 17, re-press at tick 20 → pulse at re-press; next repeat 18 ticks later, not at original tick 18.
- rst driven low mid-REPEAT with raw_left held → all outputs 0 immediately; after rst goes high, cmd_left pulses once (prev cleared) and DAS restarts from DELAY.
